trigger_qualifier: RTL and testbench

Sits directly downstream of the FFT-bin trigger detector. Consumes its combinational per-beat Trigger flag, qualified by the FFT output stream handshake, and decides per FFT frame whether a ping is present. Requires a run of consecutive qualifying frames before declaring a ping. Opens a capture window of fixed frame length, then enforces a holdoff so one ping (and its reflections) yields one detection.

---
 rtl/trigger_qualifier.sv | 158 +++++++++++++++
 tb/tb_trigger_qualifier.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/trigger_qualifier.sv
// Per-frame ping qualifier: counts trigger hits per FFT frame, declares a ping
// after a run of qualifying frames, then runs a capture window and a holdoff.
module trigger_qualifier #(
  parameter int unsigned MIN_HITS       = 2,
  parameter int unsigned CONSEC_FRAMES  = 2,
  parameter int unsigned CAPTURE_FRAMES = 4,
  parameter int unsigned HOLDOFF_FRAMES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Arm,
  input  logic        Trigger,
  input  logic        T_VALID,
  input  logic        T_READY,
  input  logic        T_LAST,
  output logic        Ping_Detected,
  output logic        Capture_Active,
  output logic [7:0]  Frame_Hits,
  output logic [15:0] Ping_Count,
  output logic [1:0]  State
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMING  = 2'b01,
    CAPTURE = 2'b10,
    HOLDOFF = 2'b11
  } state_e;

  localparam logic [7:0] MIN_HITS_C = 8'(MIN_HITS);
  localparam logic [3:0] CONSEC_C   = 4'(CONSEC_FRAMES);
  localparam logic [7:0] CAPTURE_C  = 8'(CAPTURE_FRAMES);
  localparam logic [7:0] HOLDOFF_C  = 8'(HOLDOFF_FRAMES);

  state_e      state_q, state_d;
  logic [7:0]  hit_cnt_q, hit_cnt_d;
  logic [7:0]  frame_hits_q, frame_hits_d;
  logic [3:0]  run_q, run_d;
  logic [7:0]  frm_cnt_q, frm_cnt_d;
  logic [15:0] ping_cnt_q, ping_cnt_d;
  logic        ping_q, ping_d;

  logic        accept, hit, frame_end, qualify;
  logic [7:0]  hit_sum;
  logic [3:0]  run_inc;
  logic [7:0]  frm_inc;

  assign accept    = T_VALID & T_READY;
  assign hit       = accept & Trigger;
  assign frame_end = accept & T_LAST;

  // Running count including this beat's hit, so a hit on T_LAST lands in its own frame.
  assign hit_sum = (hit && hit_cnt_q != 8'hFF) ? hit_cnt_q + 8'd1 : hit_cnt_q;
  assign qualify = (hit_sum >= MIN_HITS_C);
  assign run_inc = run_q + 4'd1;
  assign frm_inc = frm_cnt_q + 8'd1;

  // NOTE: every _d gets a default before any branch so no path leaves it
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d      = state_q;
    hit_cnt_d    = hit_cnt_q;
    frame_hits_d = frame_hits_q;
    run_d        = run_q;
    frm_cnt_d    = frm_cnt_q;
    ping_cnt_d   = ping_cnt_q;
    ping_d       = 1'b0;

    if (accept) begin
      hit_cnt_d = hit_sum;
      if (frame_end) begin
        frame_hits_d = hit_sum;
        hit_cnt_d    = 8'd0;
      end
    end

    if (!Arm) begin
      state_d   = IDLE;
      run_d     = 4'd0;
      frm_cnt_d = 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = ARMING;
          run_d     = 4'd0;
          frm_cnt_d = 8'd0;
        end
        ARMING: begin
          if (frame_end) begin
            if (!qualify) begin
              run_d = 4'd0;
            end else if (run_inc == CONSEC_C) begin
              state_d    = CAPTURE;
              run_d      = 4'd0;
              frm_cnt_d  = 8'd0;
              ping_d     = 1'b1;
              ping_cnt_d = ping_cnt_q + 16'd1;
            end else begin
              run_d = run_inc;
            end
          end
        end
        CAPTURE: begin
          if (frame_end) begin
            if (frm_inc == CAPTURE_C) begin
              state_d   = (HOLDOFF_FRAMES == 0) ? ARMING : HOLDOFF;
              frm_cnt_d = 8'd0;
              run_d     = 4'd0;
            end else begin
              frm_cnt_d = frm_inc;
            end
          end
        end
        HOLDOFF: begin
          if (frame_end) begin
            if (frm_inc == HOLDOFF_C) begin
              state_d   = ARMING;
              frm_cnt_d = 8'd0;
              run_d     = 4'd0;
            end else begin
              frm_cnt_d = frm_inc;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      hit_cnt_q    <= 8'd0;
      frame_hits_q <= 8'd0;
      run_q        <= 4'd0;
      frm_cnt_q    <= 8'd0;
      ping_cnt_q   <= 16'd0;
      ping_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hit_cnt_q    <= hit_cnt_d;
      frame_hits_q <= frame_hits_d;
      run_q        <= run_d;
      frm_cnt_q    <= frm_cnt_d;
      ping_cnt_q   <= ping_cnt_d;
      ping_q       <= ping_d;
    end
  end

  assign Ping_Detected  = ping_q;
  assign Capture_Active = (state_q == CAPTURE);
  assign Frame_Hits     = frame_hits_q;
  assign Ping_Count     = ping_cnt_q;
  assign State          = state_q;

endmodule

// File: tb/tb_trigger_qualifier.sv
// Self-checking bench for trigger_qualifier: directed scenarios followed by
// randomized frames, all compared every cycle against a frame-level model.
module tb_trigger_qualifier;

  localparam int MIN_HITS = 2;
  localparam int CONSEC   = 2;
  localparam int CAPF     = 4;
  localparam int HOLDF    = 8;

  logic        clk = 1'b0;
  logic        reset, Arm, Trigger, T_VALID, T_READY, T_LAST;
  logic        Ping_Detected, Capture_Active;
  logic [7:0]  Frame_Hits;
  logic [15:0] Ping_Count;
  logic [1:0]  State;

  always #5 clk = ~clk;

  trigger_qualifier #(
    .MIN_HITS(MIN_HITS), .CONSEC_FRAMES(CONSEC),
    .CAPTURE_FRAMES(CAPF), .HOLDOFF_FRAMES(HOLDF)
  ) dut (
    .clk(clk), .reset(reset), .Arm(Arm), .Trigger(Trigger),
    .T_VALID(T_VALID), .T_READY(T_READY), .T_LAST(T_LAST),
    .Ping_Detected(Ping_Detected), .Capture_Active(Capture_Active),
    .Frame_Hits(Frame_Hits), .Ping_Count(Ping_Count), .State(State)
  );

  int checks = 0;
  int errors = 0;
  bit arm_lvl = 1'b0;

  // Reference model: phase 0 idle, 1 arming, 2 capture, 3 holdoff.
  // m_left counts down the frames remaining in capture/holdoff.
  int m_hits = 0, m_frame_hits = 0, m_pings = 0;
  int m_phase = 0, m_run = 0, m_left = 0;
  bit m_pulse = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit arm, input bit trig,
                            input bit v, input bit r, input bit last);
    bit acc, fe;
    acc     = v && r;
    fe      = acc && last;
    m_pulse = 1'b0;
    if (rst) begin
      m_hits = 0; m_frame_hits = 0; m_pings = 0;
      m_phase = 0; m_run = 0; m_left = 0;
    end else begin
      if (acc && trig) m_hits = (m_hits < 255) ? m_hits + 1 : 255;
      if (fe) begin
        m_frame_hits = m_hits;
        m_hits       = 0;
      end
      if (!arm) begin
        m_phase = 0;
        m_run   = 0;
      end else begin
        case (m_phase)
          0: begin m_phase = 1; m_run = 0; end
          1: if (fe) begin
            m_run = (m_frame_hits >= MIN_HITS) ? m_run + 1 : 0;
            if (m_run == CONSEC) begin
              m_phase = 2; m_left = CAPF; m_pulse = 1'b1;
              m_pings = (m_pings + 1) % 65536; m_run = 0;
            end
          end
          2: if (fe) begin
            m_left--;
            if (m_left == 0) begin
              m_phase = (HOLDF == 0) ? 1 : 3;
              m_left  = HOLDF;
              m_run   = 0;
            end
          end
          default: if (fe) begin
            m_left--;
            if (m_left == 0) begin m_phase = 1; m_run = 0; end
          end
        endcase
      end
    end
  endtask

  task automatic step(input bit rst, input bit trig, input bit v, input bit r, input bit last);
    reset = rst; Arm = arm_lvl; Trigger = trig;
    T_VALID = v; T_READY = r; T_LAST = last;
    @(posedge clk);
    model_step(rst, arm_lvl, trig, v, r, last);
    #1;
    check("ping_detected", 32'(Ping_Detected), 32'(m_pulse));
    check("capture_active", 32'(Capture_Active), 32'(m_phase == 2));
    check("frame_hits", 32'(Frame_Hits), m_frame_hits);
    check("ping_count", 32'(Ping_Count), m_pings);
    check("state", 32'(State), m_phase);
  endtask

  // One frame of len beats, Trigger on beats [first, first+nhits); random
  // back-pressure and bubble cycles with junk Trigger/T_LAST when stall_pct > 0.
  task automatic send_frame(input int len, input int first, input int nhits, input int stall_pct);
    for (int b = 0; b < len; b++) begin
      while (stall_pct > 0 && int'($urandom_range(99)) < stall_pct) begin
        if ($urandom_range(1) == 1)
          step(1'b0, 1'($urandom_range(1)), 1'b1, 1'b0, 1'($urandom_range(1)));
        else
          step(1'b0, 1'($urandom_range(1)), 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
      end
      step(1'b0, (b >= first && b < first + nhits), 1'b1, 1'b1, (b == len - 1));
    end
  endtask

  initial begin
    // Reset and arming
    arm_lvl = 1'b0;
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_state", 32'(State), 0);
    check("reset_count", 32'(Ping_Count), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    arm_lvl = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("armed_state", 32'(State), 1);

    // Two qualifying 64-beat frames -> first ping
    send_frame(64, 16, 2, 0);
    check("t1_no_ping_yet", 32'(Ping_Count), 0);
    send_frame(64, 16, 2, 0);
    check("t1_ping_pulse", 32'(Ping_Detected), 1);
    check("t1_ping_count", 32'(Ping_Count), 1);
    check("t1_state", 32'(State), 2);
    check("t1_frame_hits", 32'(Frame_Hits), 2);

    // Continuous qualifying frames through capture and holdoff
    repeat (3) send_frame(24, 2, 3, 0);
    check("t4_capture_3", 32'(Capture_Active), 1);
    send_frame(24, 2, 3, 0);
    check("t4_capture_end", 32'(Capture_Active), 0);
    check("t4_holdoff", 32'(State), 3);
    repeat (7) send_frame(24, 2, 3, 0);
    check("t4_holdoff_7", 32'(State), 3);
    send_frame(24, 2, 3, 0);
    check("t4_rearmed", 32'(State), 1);
    send_frame(24, 2, 3, 0);
    check("t4_one_more", 32'(Ping_Count), 1);
    send_frame(24, 2, 3, 0);
    check("t4_second_ping", 32'(Ping_Detected), 1);
    check("t4_ping_count", 32'(Ping_Count), 2);

    // Arm dropped mid-holdoff
    repeat (4) send_frame(16, 2, 3, 0);
    repeat (3) send_frame(16, 2, 5, 0);
    check("t6_in_holdoff", 32'(State), 3);
    arm_lvl = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t6_disarm_idle", 32'(State), 0);
    check("t6_hits_kept", 32'(Frame_Hits), 5);
    arm_lvl = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Single-hit frames never qualify
    repeat (10) send_frame(16, 4, 1, 0);
    check("t2_state", 32'(State), 1);
    check("t2_frame_hits", 32'(Frame_Hits), 1);
    check("t2_no_ping", 32'(Ping_Count), 2);

    // Q, N, Q, Q -> detection only after the fourth frame
    send_frame(16, 2, 2, 0);
    send_frame(16, 2, 1, 0);
    send_frame(16, 2, 2, 0);
    check("t3_run_reset", 32'(Ping_Count), 2);
    send_frame(16, 2, 2, 0);
    check("t3_ping", 32'(Ping_Detected), 1);
    check("t3_ping_count", 32'(Ping_Count), 3);

    // Stalled Trigger+T_LAST beat counts once when finally accepted
    for (int b = 0; b < 15; b++) step(1'b0, (b == 3 || b == 4), 1'b1, 1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("t5_stall_no_update", 32'(Frame_Hits), 2);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("t5_last_hit_counted", 32'(Frame_Hits), 3);

    // Reset mid-capture
    check("t6_in_capture", 32'(State), 2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t6_rst_state", 32'(State), 0);
    check("t6_rst_capture", 32'(Capture_Active), 0);
    check("t6_rst_ping", 32'(Ping_Detected), 0);
    check("t6_rst_hits", 32'(Frame_Hits), 0);
    check("t6_rst_count", 32'(Ping_Count), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Hit counter saturation
    send_frame(300, 0, 300, 0);
    check("sat_frame_hits", 32'(Frame_Hits), 255);

    // Randomized frames with back-pressure, arm toggling and occasional reset
    repeat (250) begin
      int len;
      if ($urandom_range(99) < 4) arm_lvl = ~arm_lvl;
      if (!arm_lvl && $urandom_range(99) < 50) arm_lvl = 1'b1;
      if ($urandom_range(99) < 1) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat ($urandom_range(2))
        step(1'b0, 1'($urandom_range(1)), 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
      len = int'($urandom_range(20, 3));
      send_frame(len, int'($urandom_range(len - 1)), int'($urandom_range(4)), 20);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
